zx_keymatrix: RTL
=================

ZX_KEYMATRIX -- requirements
Module: zx_keymatrix

Interface
REQ-001 SHALL have port: clock  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high; clears all state.
REQ-003 SHALL have port: kstrobe  in  1  one-cycle pulse, key event valid.
REQ-004 SHALL have port: kpress  in  1  1 = make, 0 = break; sampled with kstrobe.
REQ-005 SHALL have port: kext  in  1  1 = E0-extended scancode; sampled with kstrobe.
REQ-006 SHALL have port: kcode  in  8  PS/2 set-2 scancode; sampled with kstrobe.
REQ-007 SHALL have port: row  in  8  CPU address A15..A8, active-low row select.
REQ-008 SHALL have port: col  out  5  active-low column data, D4..D0.
REQ-009 SHALL have port: nmi  out  1  one-cycle pulse on F5 make.
REQ-010 SHALL have port: capslock  out  1  caps-lock LED state, toggles on CapsLock make.

Function
REQ-011 SHALL hold a 40-bit native matrix (8 rows x 5 cols, 1 = pressed), bit order per row: col0 first.
REQ-012 SHALL map rows: r0 CS,Z,X,C,V; r1 A,S,D,F,G; r2 Q,W,E,R,T; r3 1,2,3,4,5; r4 0,9,8,7,6; r5 P,O,I,U,Y; r6 Enter,L,K,J,H; r7 Space,SS,M,N,B.
REQ-013 SHALL map non-extended codes: 1-0 = 16,1E,26,25,2E,36,3D,3E,46,45; Q-P = 15,1D,24,2D,2C,35,3C,43,44,4D; A-L = 1C,1B,23,2B,34,33,3B,42,4B; Z-M = 1A,22,21,2A,32,31,3A; Enter 5A; Space 29; CS = 12 (LShift); SS = 59 (RShift) and 14 (LCtrl).
REQ-014 SHALL map extended codes: E0 5A = Enter; E0 14 = SS; all other extended codes except arrows ignored.
REQ-015 SHALL, on kstrobe with a native mapping, set the bit to kpress; unmapped codes leave all state unchanged.
REQ-016 SHALL hold six compound flags, each set on make / cleared on break: BS (66) = CS+0; CapsLock (58) = CS+2; Left (E0 6B) = CS+5; Down (E0 72) = CS+6; Up (E0 75) = CS+7; Right (E0 74) = CS+8.
REQ-017 SHALL form effective matrix = native OR compound contributions; CS effective = native CS OR any compound flag.
REQ-018 SHALL release a compound's CS only when no other compound flag and not native CS remain set (no premature CS release).
REQ-019 SHALL compute col = NOT(OR over rows r where row[r]=0 of effective row r); row = FF gives col = 1F.
REQ-020 SHALL register col: change on row or matrix visible exactly one clock after the input edge.
REQ-021 SHALL pulse nmi for exactly one clock, the cycle after kstrobe with F5 (03, non-extended) make; F5 break and auto-repeat makes while held produce no pulse.
REQ-022 SHALL toggle capslock on CapsLock make only when its flag was clear (auto-repeat ignored).
REQ-023 SHALL treat repeated make of a held key as no-op and break of an unpressed key as no-op.
REQ-024 SHALL ignore kpress/kext/kcode when kstrobe = 0.

Reset
REQ-025 SHALL, with reset = 1 at a clock edge, clear native matrix, compound flags, capslock, nmi to 0 and col to 1F; reset dominates a simultaneous kstrobe.
REQ-026 SHALL not require reset to be released by any key event; keys held across reset read released until a new make.

Verification
REQ-027 SHALL verify: reset, then make 1C (A), row = FD -> col = 1E one clock after; row = FE -> col = 1F; break 1C -> col = 1F.
REQ-028 SHALL verify: make 66 (BS), row = EE -> col = 1E (CS in r0, 0 in r4 both low).
REQ-029 SHALL verify: make E0 6B, make E0 72, break E0 6B, row = FE -> col = 1E (CS held); break E0 72 -> col = 1F.
REQ-030 SHALL verify: make 12 (LShift) then make/break 66, row = FE -> col stays 1E until 12 break.
REQ-031 SHALL verify: make 03 twice, break 03 -> nmi high exactly one cycle total; make 58 twice -> capslock = 1.
REQ-032 SHALL verify: make 15 (Q), assert reset with simultaneous kstrobe make 1D -> after reset, row = 00 gives col = 1F.

Source files
------------

// File: rtl/zx_keymatrix.sv
// PS/2 set-2 key events folded into a ZX Spectrum 8x5 keyboard matrix, with
// compound keys (cursor, BS, CapsLock) that add Caps Shift, plus NMI and LED state.
module zx_keymatrix (
    input  logic       clock,
    input  logic       reset,
    input  logic       kstrobe,
    input  logic       kpress,
    input  logic       kext,
    input  logic [7:0] kcode,
    input  logic [7:0] row,
    output logic [4:0] col,
    output logic       nmi,
    output logic       capslock
);

    localparam logic [5:0] CMP_BS    = 6'b000001;
    localparam int         CMP_CAPS  = 1;

    // {valid, bit index}; bit index = row * 5 + column
    function automatic logic [6:0] f_native(input logic ext, input logic [7:0] code);
        logic [6:0] res;
        res = 7'd0;
        case ({ext, code})
            9'h012: res = {1'b1, 6'd0};
            9'h01A: res = {1'b1, 6'd1};
            9'h022: res = {1'b1, 6'd2};
            9'h021: res = {1'b1, 6'd3};
            9'h02A: res = {1'b1, 6'd4};
            9'h01C: res = {1'b1, 6'd5};
            9'h01B: res = {1'b1, 6'd6};
            9'h023: res = {1'b1, 6'd7};
            9'h02B: res = {1'b1, 6'd8};
            9'h034: res = {1'b1, 6'd9};
            9'h015: res = {1'b1, 6'd10};
            9'h01D: res = {1'b1, 6'd11};
            9'h024: res = {1'b1, 6'd12};
            9'h02D: res = {1'b1, 6'd13};
            9'h02C: res = {1'b1, 6'd14};
            9'h016: res = {1'b1, 6'd15};
            9'h01E: res = {1'b1, 6'd16};
            9'h026: res = {1'b1, 6'd17};
            9'h025: res = {1'b1, 6'd18};
            9'h02E: res = {1'b1, 6'd19};
            9'h045: res = {1'b1, 6'd20};
            9'h046: res = {1'b1, 6'd21};
            9'h03E: res = {1'b1, 6'd22};
            9'h03D: res = {1'b1, 6'd23};
            9'h036: res = {1'b1, 6'd24};
            9'h04D: res = {1'b1, 6'd25};
            9'h044: res = {1'b1, 6'd26};
            9'h043: res = {1'b1, 6'd27};
            9'h03C: res = {1'b1, 6'd28};
            9'h035: res = {1'b1, 6'd29};
            9'h05A: res = {1'b1, 6'd30};
            9'h15A: res = {1'b1, 6'd30};
            9'h04B: res = {1'b1, 6'd31};
            9'h042: res = {1'b1, 6'd32};
            9'h03B: res = {1'b1, 6'd33};
            9'h033: res = {1'b1, 6'd34};
            9'h029: res = {1'b1, 6'd35};
            9'h059: res = {1'b1, 6'd36};
            9'h014: res = {1'b1, 6'd36};
            9'h114: res = {1'b1, 6'd36};
            9'h03A: res = {1'b1, 6'd37};
            9'h031: res = {1'b1, 6'd38};
            9'h032: res = {1'b1, 6'd39};
            default: res = 7'd0;
        endcase
        return res;
    endfunction

    // {valid, flag index}: 0 BS, 1 CapsLock, 2 Left, 3 Down, 4 Up, 5 Right
    function automatic logic [3:0] f_compound(input logic ext, input logic [7:0] code);
        logic [3:0] res;
        res = 4'd0;
        case ({ext, code})
            9'h066: res = {1'b1, 3'd0};
            9'h058: res = {1'b1, 3'd1};
            9'h16B: res = {1'b1, 3'd2};
            9'h172: res = {1'b1, 3'd3};
            9'h175: res = {1'b1, 3'd4};
            9'h174: res = {1'b1, 3'd5};
            default: res = 4'd0;
        endcase
        return res;
    endfunction

    logic [39:0] r_native;
    logic [5:0]  r_cmp;
    logic        r_f5_held;
    logic        r_capslock;
    logic        r_nmi;
    logic [4:0]  r_col;

    logic [6:0]  w_nat;
    logic [3:0]  w_cdec;
    logic        w_is_f5;
    logic [39:0] w_eff;
    logic [4:0]  w_or;

    assign w_nat   = f_native(kext, kcode);
    assign w_cdec  = f_compound(kext, kcode);
    assign w_is_f5 = !kext && (kcode == 8'h03);

    // Caps Shift stays down while native CS or any compound key is still held.
    always_comb begin
        w_eff     = r_native;
        w_eff[0]  = r_native[0] | (|r_cmp);
        w_eff[20] = r_native[20] | (r_cmp & CMP_BS) != 6'd0;
        w_eff[16] = r_native[16] | r_cmp[1];
        w_eff[19] = r_native[19] | r_cmp[2];
        w_eff[24] = r_native[24] | r_cmp[3];
        w_eff[23] = r_native[23] | r_cmp[4];
        w_eff[22] = r_native[22] | r_cmp[5];
    end

    always_comb begin
        w_or = 5'd0;
        for (int r = 0; r < 8; r++) begin
            if (!row[r]) w_or = w_or | w_eff[r*5 +: 5];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_native   <= 40'd0;
            r_cmp      <= 6'd0;
            r_f5_held  <= 1'b0;
            r_capslock <= 1'b0;
            r_nmi      <= 1'b0;
            r_col      <= 5'h1F;
        end else begin
            r_col <= ~w_or;
            r_nmi <= 1'b0;
            if (kstrobe) begin
                if (w_nat[6]) r_native[w_nat[5:0]] <= kpress;
                if (w_cdec[3]) begin
                    r_cmp[w_cdec[2:0]] <= kpress;
                    if ((w_cdec[2:0] == 3'(CMP_CAPS)) && kpress && !r_cmp[CMP_CAPS])
                        r_capslock <= ~r_capslock;
                end
                // Typematic repeats of a held F5 must not retrigger the NMI.
                if (w_is_f5) begin
                    r_nmi     <= kpress && !r_f5_held;
                    r_f5_held <= kpress;
                end
            end
        end
    end

    assign col      = r_col;
    assign nmi      = r_nmi;
    assign capslock = r_capslock;

endmodule
